// File: rtl/is_array_feeder.sv
// is_array_feeder
//
// Operand feeder for an input-stationary PE array. A tile runs in three phases:
//   LOAD   - ROWS input vectors are accepted from the input stream and presented to the
//            top PE row with act_en, one cycle after each accept (bottom row loads first).
//   STREAM - k_len weight vectors are accepted from the weight stream. Each vector passes
//            through a common output register, then row r adds r more register stages,
//            so lane r reaches row r r cycles after lane 0 reaches row 0.
//   DRAIN  - no new data; waits ROWS-1 cycles for the last vector to reach row ROWS-1.
// A one-cycle done pulse follows, then the block returns to idle.
// Operands are passed through unmodified.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, k_len         tile start pulse and weight beat count (sampled in idle only)
//   in_valid/ready/data  input-vector stream, lane c = in_data[c*INPUT_WIDTH +: INPUT_WIDTH]
//   w_valid/ready/data   weight-vector stream, lane r = w_data[r*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   act_out, act_en      inputs and load enable for the PE array
//   wt_out, wt_en        skewed weights and per-row process enables
//   busy, done           tile in progress / one-cycle completion pulse
module is_array_feeder #(
    parameter int unsigned INPUT_WIDTH  = 16,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLS         = 4,
    parameter int unsigned K_WIDTH      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [K_WIDTH-1:0]             k_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [COLS*INPUT_WIDTH-1:0]    in_data,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [ROWS*WEIGHT_WIDTH-1:0]   w_data,
    output logic [COLS*INPUT_WIDTH-1:0]    act_out,
    output logic                           act_en,
    output logic [ROWS*WEIGHT_WIDTH-1:0]   wt_out,
    output logic [ROWS-1:0]                wt_en,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [2:0] {StIdle, StLoad, StStream, StDrain, StDone} state_e;

    localparam logic [K_WIDTH-1:0] LoadLast  = K_WIDTH'(ROWS - 1);
    localparam logic [K_WIDTH-1:0] DrainLast = K_WIDTH'((ROWS > 1) ? (ROWS - 2) : 0);

    state_e               state_q, state_d;
    logic [K_WIDTH-1:0]   k_q, k_d;
    logic [K_WIDTH-1:0]   cnt_q, cnt_d;

    logic                 in_acc;
    logic                 w_acc;

    logic [COLS*INPUT_WIDTH-1:0]  act_q;
    logic                         act_en_q;
    logic [ROWS*WEIGHT_WIDTH-1:0] wt_head_q;
    logic                         wt_head_en_q;

    assign in_acc = in_valid & in_ready;
    assign w_acc  = w_valid & w_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. One counter serves LOAD beats, STREAM beats and DRAIN cycles;
    // it never counts past k_len-1, so k_len = 2^K_WIDTH-1 cannot wrap.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = '0;
                    if (k_len == '0) begin
                        state_d = StDone;
                    end else begin
                        k_d     = k_len;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (in_acc) begin
                    if (cnt_q == LoadLast) begin
                        cnt_d   = '0;
                        state_d = StStream;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStream: begin
                if (w_acc) begin
                    if (cnt_q == k_q - 1'b1) begin
                        cnt_d   = '0;
                        // A single row has nothing to drain.
                        state_d = (ROWS == 1) ? StDone : StDrain;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready = 1'b0;
        w_ready  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            StIdle:   busy     = 1'b0;
            StLoad:   in_ready = 1'b1;
            StStream: w_ready  = 1'b1;
            StDone:   done     = 1'b1;
            default:  ;
        endcase
    end

    // Activation register holds its value between accepts; weight head register injects
    // a zero bubble whenever no weight beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q        <= '0;
            act_en_q     <= 1'b0;
            wt_head_q    <= '0;
            wt_head_en_q <= 1'b0;
        end else begin
            act_en_q     <= in_acc;
            if (in_acc) begin
                act_q <= in_data;
            end
            wt_head_q    <= w_acc ? w_data : '0;
            wt_head_en_q <= w_acc;
        end
    end

    assign act_out = act_q;
    assign act_en  = act_en_q;

    assign wt_out[WEIGHT_WIDTH-1:0] = wt_head_q[WEIGHT_WIDTH-1:0];
    assign wt_en[0]                 = wt_head_en_q;

    // Row r gets an r-deep delay chain behind the head register.
    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        logic [WEIGHT_WIDTH-1:0] dly_q    [r];
        logic                    dly_en_q [r];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < r; i++) begin
                    dly_q[i]    <= '0;
                    dly_en_q[i] <= 1'b0;
                end
            end else begin
                dly_q[0]    <= wt_head_q[r*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                dly_en_q[0] <= wt_head_en_q;
                for (int i = 1; i < r; i++) begin
                    dly_q[i]    <= dly_q[i-1];
                    dly_en_q[i] <= dly_en_q[i-1];
                end
            end
        end

        assign wt_out[r*WEIGHT_WIDTH +: WEIGHT_WIDTH] = dly_q[r-1];
        assign wt_en[r]                               = dly_en_q[r-1];
    end

endmodule

// File: tb/tb_is_array_feeder.sv
// Testbench for is_array_feeder: directed tiles checked against a cycle-indexed
// expectation model plus hand-computed literal values.
module tb_is_array_feeder;

    localparam int IW   = 16;
    localparam int WW   = 16;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 8;
    localparam int N    = 4096;

    logic                  clk      = 1'b0;
    logic                  rst_n    = 1'b0;
    logic                  start    = 1'b0;
    logic [KW-1:0]         k_len    = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [COLS*IW-1:0]    in_data  = '0;
    logic                  w_valid  = 1'b0;
    logic                  w_ready;
    logic [ROWS*WW-1:0]    w_data   = '0;
    logic [COLS*IW-1:0]    act_out;
    logic                  act_en;
    logic [ROWS*WW-1:0]    wt_out;
    logic [ROWS-1:0]       wt_en;
    logic                  busy;
    logic                  done;

    is_array_feeder #(
        .INPUT_WIDTH (IW),
        .WEIGHT_WIDTH(WW),
        .ROWS        (ROWS),
        .COLS        (COLS),
        .K_WIDTH     (KW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .k_len   (k_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .act_out (act_out),
        .act_en  (act_en),
        .wt_out  (wt_out),
        .wt_en   (wt_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: phase 0 idle, 1 loading, 2 streaming, 3 draining/done.
    int              cyc        = 0;
    int              phase      = 0;
    int              load_left  = 0;
    int              w_left     = 0;
    int              k_m        = 0;
    int              done_cycle = -1;
    logic [63:0]     m_act      = '0;
    logic            m_act_en   = 1'b0;
    logic [ROWS-1:0] exp_wen [N];
    logic [63:0]     exp_wd  [N];

    int row_cnt [ROWS];
    int act_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: each accepted weight beat is scheduled onto row r at (accept cycle + r).
    initial begin
        for (int i = 0; i < N; i++) begin
            exp_wen[i] = '0;
            exp_wd[i]  = '0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                phase      = 0;
                m_act      = '0;
                m_act_en   = 1'b0;
                done_cycle = -1;
                for (int i = cyc; i < N; i++) begin
                    exp_wen[i] = '0;
                    exp_wd[i]  = '0;
                end
            end else begin
                cyc++;
                m_act_en = 1'b0;
                case (phase)
                    0: if (start) begin
                        if (k_len == 0) begin
                            phase      = 3;
                            done_cycle = cyc;
                        end else begin
                            phase     = 1;
                            load_left = ROWS;
                            k_m       = int'(k_len);
                        end
                    end
                    1: if (in_valid) begin
                        m_act    = in_data;
                        m_act_en = 1'b1;
                        load_left--;
                        if (load_left == 0) begin
                            phase  = 2;
                            w_left = k_m;
                        end
                    end
                    2: if (w_valid) begin
                        for (int r = 0; r < ROWS; r++) begin
                            exp_wen[cyc+r][r]           = 1'b1;
                            exp_wd[cyc+r][r*WW +: WW]   = w_data[r*WW +: WW];
                        end
                        w_left--;
                        if (w_left == 0) begin
                            phase      = 3;
                            done_cycle = cyc + ROWS - 1;
                        end
                    end
                    default: if (cyc - 1 == done_cycle) phase = 0;
                endcase
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_busy",     64'(busy),     64'(phase != 0));
            chk("m_done",     64'(done),     64'(phase == 3 && cyc == done_cycle));
            chk("m_in_ready", 64'(in_ready), 64'(phase == 1));
            chk("m_w_ready",  64'(w_ready),  64'(phase == 2));
            chk("m_act_en",   64'(act_en),   64'(m_act_en));
            chk("m_act_out",  64'(act_out),  m_act);
            chk("m_wt_en",    64'(wt_en),    64'(exp_wen[cyc]));
            chk("m_wt_out",   64'(wt_out),   exp_wd[cyc]);
        end
    end

    task automatic step();
        @(negedge clk);
        for (int r = 0; r < ROWS; r++) row_cnt[r] += int'(wt_en[r]);
        act_cnt += int'(act_en);
    endtask

    task automatic clear_counts();
        for (int r = 0; r < ROWS; r++) row_cnt[r] = 0;
        act_cnt = 0;
    endtask

    task automatic load_tile(input int k);
        start = 1'b1;
        k_len = KW'(k);
        step();
        start = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            in_valid = 1'b1;
            in_data  = {16'(i + 200), 16'(i + 100), 16'(i + 50), 16'(i + 1)};
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("done_seen", 64'(done), 64'(1));
        step();
    endtask

    logic [63:0] preload_exp [4];
    int          n;

    initial begin
        preload_exp[0] = 64'h0014_0013_0012_0011;
        preload_exp[1] = 64'h0025_0024_0023_0022;
        preload_exp[2] = 64'h0036_0035_0034_0033;
        preload_exp[3] = 64'h0047_0046_0045_0044;
        for (int r = 0; r < ROWS; r++) row_cnt[r] = 0;

        repeat (3) step();
        chk("reset_busy",  64'(busy),   64'(0));
        chk("reset_wt_en", 64'(wt_en),  64'(0));
        rst_n = 1'b1;
        step();

        // Preload + skew, with w_valid held during LOAD (must be ignored)
        clear_counts();
        start   = 1'b1;
        k_len   = 8'd3;
        w_valid = 1'b1;
        w_data  = 64'hdead_beef_cafe_f00d;
        step();
        start    = 1'b0;
        chk("load_w_ready", 64'(w_ready), 64'(0));
        in_valid = 1'b1;
        in_data  = preload_exp[0];
        for (int i = 0; i < 4; i++) begin
            step();
            chk("preload_act_en",  64'(act_en), 64'(1));
            chk("preload_act_out", act_out,     preload_exp[i]);
            if (i < 3) begin
                in_data = preload_exp[i+1];
            end else begin
                in_valid = 1'b0;
                chk("stream_w_ready", 64'(w_ready), 64'(1));
                w_data = {16'd4, 16'd3, 16'd2, 16'd1};
            end
        end
        step();
        w_valid = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            chk("skew_en",   64'(wt_en),               64'(1) << r);
            chk("skew_data", 64'(wt_out[r*WW +: WW]),  64'(r + 1));
            if (r < ROWS - 1) step();
        end
        w_valid = 1'b1;
        w_data  = {16'd8, 16'd7, 16'd6, 16'd5};
        step();
        w_data  = {16'd12, 16'd11, 16'd10, 16'd9};
        step();
        w_valid = 1'b0;
        wait_done(n);
        chk("done_latency", 64'(n), 64'(3));
        chk("preload_act_cnt", 64'(act_cnt), 64'(4));

        // Bubbles: 1,0,1,0,1
        clear_counts();
        load_tile(3);
        for (int i = 0; i < 5; i++) begin
            w_valid = (i % 2 == 0);
            w_data  = {16'(i + 40), 16'(i + 30), 16'(i + 20), 16'(i + 10)};
            step();
        end
        w_valid = 1'b0;
        wait_done(n);
        for (int r = 0; r < ROWS; r++) chk("bubble_row_cnt", 64'(row_cnt[r]), 64'(3));

        // k_len = 0
        clear_counts();
        start = 1'b1;
        k_len = 8'd0;
        step();
        start = 1'b0;
        chk("k0_done", 64'(done), 64'(1));
        chk("k0_busy", 64'(busy), 64'(1));
        step();
        chk("k0_done_after", 64'(done), 64'(0));
        chk("k0_busy_after", 64'(busy), 64'(0));
        chk("k0_no_wt_en",   64'(row_cnt[0] + row_cnt[3]), 64'(0));
        chk("k0_no_act_en",  64'(act_cnt), 64'(0));

        // start while busy, w_valid during LOAD: tile keeps k_len=3
        clear_counts();
        start = 1'b1;
        k_len = 8'd3;
        step();
        k_len   = 8'd9;
        w_valid = 1'b1;
        w_data  = 64'h1111_2222_3333_4444;
        for (int i = 0; i < ROWS; i++) begin
            in_valid = 1'b1;
            in_data  = {4{16'(i + 7)}};
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_data = {4{16'(i + 60)}};
            step();
        end
        w_valid = 1'b0;
        start   = 1'b0;
        wait_done(n);
        chk("busy_start_latency", 64'(n), 64'(3));
        chk("busy_start_row0",    64'(row_cnt[0]), 64'(3));

        // k_len = 255 completes without wrap
        clear_counts();
        load_tile(255);
        w_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            w_data = {16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3)};
            step();
        end
        w_valid = 1'b0;
        wait_done(n);
        for (int r = 0; r < ROWS; r++) chk("kmax_row_cnt", 64'(row_cnt[r]), 64'(255));

        // Asynchronous reset mid-STREAM
        load_tile(5);
        w_valid = 1'b1;
        w_data  = 64'h0aaa_0bbb_0ccc_0ddd;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",     64'(busy),     64'(0));
        chk("rst_w_ready",  64'(w_ready),  64'(0));
        chk("rst_act_out",  act_out,       64'(0));
        chk("rst_wt_out",   wt_out,        64'(0));
        chk("rst_wt_en",    64'(wt_en),    64'(0));
        w_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_no_done", 64'(done), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1);
    end

endmodule
